// File: rtl/descram_pkg.sv
// Shared types and the 802.11a LFSR step (x^7 + x^4 + 1) for the parallel descrambler.
package descram_pkg;

    localparam int LFSR_LEN = 7;
    localparam int TAP_HI   = 6;
    localparam int TAP_LO   = 3;
    localparam int MAX_DW   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        RUN
    } state_t;

    typedef struct packed {
        logic [LFSR_LEN-1:0] state;
        logic [MAX_DW-1:0]   dout;
    } step_t;

    // Advance the LFSR over the first n bits of din (bit 0 earliest); bits above n pass through.
    function automatic step_t lfsr_step_n(input logic [LFSR_LEN-1:0] state,
                                          input logic [MAX_DW-1:0]   din,
                                          input int                  n);
        step_t r;
        logic  fb;
        r.state = state;
        r.dout  = din;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < n) begin
                fb        = r.state[TAP_HI] ^ r.state[TAP_LO];
                r.dout[i] = din[i] ^ fb;
                r.state   = {r.state[LFSR_LEN-2:0], fb};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/descram_lfsr_unroll.sv
// Combinational DW-bit unrolled descrambler step; switches from seed recovery to
// descrambling mid-beat once seven seed bits have been shifted in.
module descram_lfsr_unroll
    import descram_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [LFSR_LEN-1:0] state_in,
    input  state_t              mode_in,
    input  logic [2:0]          rec_cnt_in,
    input  logic [DW-1:0]       din,
    output logic [LFSR_LEN-1:0] state_out,
    output state_t              mode_out,
    output logic [2:0]          rec_cnt_out,
    output logic [LFSR_LEN-1:0] seed_rec,
    output logic                seed_done,
    output logic [DW-1:0]       dout
);

    step_t step;

    always_comb begin
        state_out   = state_in;
        mode_out    = mode_in;
        rec_cnt_out = rec_cnt_in;
        seed_rec    = state_in;
        seed_done   = 1'b0;
        dout        = din;
        step        = '0;
        // NOTE: blocking updates chain the bits, so bit i sees the state left by bit i-1.
        for (int i = 0; i < DW; i++) begin
            case (mode_out)
                RECOVER: begin
                    state_out   = {state_out[LFSR_LEN-2:0], din[i]};
                    dout[i]     = 1'b0;
                    rec_cnt_out = rec_cnt_out + 3'd1;
                    if (rec_cnt_out == 3'd7) begin
                        mode_out  = RUN;
                        seed_rec  = state_out;
                        seed_done = 1'b1;
                    end
                end
                RUN: begin
                    step      = lfsr_step_n(state_out, MAX_DW'(din[i]), 1);
                    state_out = step.state;
                    dout[i]   = step.dout[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/descrambler_par.sv
// Parallel 802.11a descrambler: DW bits per beat, fixed or recovered seed,
// registered AXI-Stream output with symbol framing and alignment error reporting.
module descrambler_par
    import descram_pkg::*;
#(
    parameter int                  DW          = 8,
    parameter int                  N_SYMB_BITS = 96,
    parameter int                  START_SYMB  = 3,
    parameter int                  SEED_MODE   = 0,
    parameter logic [LFSR_LEN-1:0] SEED        = 7'b1011101
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    input  logic [7:0]          s_symb_cnt,
    output logic [DW-1:0]       m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [7:0]          m_symb_cnt,
    output logic                m_symb_last,
    output logic [LFSR_LEN-1:0] seed_out,
    output logic                seed_vld,
    output logic                err_align
);

    localparam int            CW      = $clog2(N_SYMB_BITS + 1);
    localparam logic [CW-1:0] DW_C    = CW'(DW);
    localparam logic [CW-1:0] N_C     = CW'(N_SYMB_BITS);
    localparam logic [7:0]    START_C = 8'(START_SYMB);

    state_t              state_q, state_d, mode_in, mode_out;
    logic [LFSR_LEN-1:0] lfsr_q, lfsr_in, lfsr_out, seed_rec;
    logic [2:0]          rec_cnt_q, rec_cnt_in, rec_cnt_out;
    logic                seed_done;
    logic [DW-1:0]       dout;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d, bit_base;
    logic [7:0]          prev_symb_q;
    logic                accept, start, restart, counted, misalign, symb_last;

    assign s_tready = !rst && (!m_tvalid || m_tready);
    assign accept   = s_tvalid && s_tready;

    // A START_SYMB beat opens a frame from IDLE, or re-opens one when it follows another symbol.
    assign start    = accept && (s_symb_cnt == START_C) &&
                      (state_q == IDLE || prev_symb_q != START_C);
    assign restart  = start && (state_q != IDLE);

    descram_lfsr_unroll #(.DW(DW)) u_unroll (
        .state_in    (lfsr_in),
        .mode_in     (mode_in),
        .rec_cnt_in  (rec_cnt_in),
        .din         (s_tdata),
        .state_out   (lfsr_out),
        .mode_out    (mode_out),
        .rec_cnt_out (rec_cnt_out),
        .seed_rec    (seed_rec),
        .seed_done   (seed_done),
        .dout        (dout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = s_tlast ? IDLE : mode_out;
    end

    // NOTE: each comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mode_in    = state_q;
        lfsr_in    = lfsr_q;
        rec_cnt_in = rec_cnt_q;
        if (start) begin
            rec_cnt_in = '0;
            if (SEED_MODE != 0) begin
                mode_in = RECOVER;
            end else begin
                mode_in = RUN;
                lfsr_in = SEED;
            end
        end
    end

    always_comb begin
        counted   = s_symb_cnt >= START_C;
        misalign  = (s_symb_cnt != prev_symb_q) && (bit_cnt_q != '0);
        bit_base  = misalign ? '0 : bit_cnt_q;
        symb_last = counted && (bit_base + DW_C == N_C);
        bit_cnt_d = (s_tlast || !counted || symb_last) ? '0 : bit_base + DW_C;
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= SEED;
            rec_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            prev_symb_q <= '0;
            seed_out    <= '0;
            seed_vld    <= 1'b0;
            err_align   <= 1'b0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_symb_cnt  <= '0;
            m_symb_last <= 1'b0;
        end else begin
            err_align <= accept && (misalign || restart);
            if (accept) begin
                lfsr_q      <= lfsr_out;
                rec_cnt_q   <= rec_cnt_out;
                bit_cnt_q   <= bit_cnt_d;
                prev_symb_q <= s_symb_cnt;
                m_tdata     <= dout;
                m_tvalid    <= 1'b1;
                m_tlast     <= s_tlast;
                m_symb_cnt  <= s_symb_cnt;
                m_symb_last <= symb_last;
                if (s_tlast) begin
                    seed_vld <= 1'b0;
                end else if (seed_done) begin
                    seed_out <= seed_rec;
                    seed_vld <= 1'b1;
                end else if (start) begin
                    seed_vld <= (SEED_MODE == 0);
                    if (SEED_MODE == 0) seed_out <= SEED;
                end
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_descrambler_par.sv
// Directed bench: fixed-seed DUT (DW=8), recovered-seed DUTs (DW=1 and DW=8).
module tb_descrambler_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // dut0: DW=8, fixed seed
    logic [7:0] s0_tdata, m0_tdata, s0_symb, m0_symb;
    logic       s0_tvalid, s0_tready, s0_tlast, m0_tvalid, m0_tready, m0_tlast, m0_symb_last;
    logic [6:0] seed0;
    logic       seed0_vld, err0;

    // dut1: DW=1, recovered seed
    logic [0:0] s1_tdata, m1_tdata;
    logic [7:0] s1_symb, m1_symb;
    logic       s1_tvalid, s1_tready, s1_tlast, m1_tvalid, m1_tready, m1_tlast, m1_symb_last;
    logic [6:0] seed1;
    logic       seed1_vld, err1;

    // dut2: DW=8, recovered seed (recovery ends inside a beat)
    logic [7:0] s2_tdata, m2_tdata, s2_symb, m2_symb;
    logic       s2_tvalid, s2_tready, s2_tlast, m2_tvalid, m2_tready, m2_tlast, m2_symb_last;
    logic [6:0] seed2;
    logic       seed2_vld, err2;

    descrambler_par #(.DW(8), .N_SYMB_BITS(96), .START_SYMB(3), .SEED_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .s_tdata(s0_tdata), .s_tvalid(s0_tvalid), .s_tready(s0_tready),
        .s_tlast(s0_tlast), .s_symb_cnt(s0_symb), .m_tdata(m0_tdata), .m_tvalid(m0_tvalid),
        .m_tready(m0_tready), .m_tlast(m0_tlast), .m_symb_cnt(m0_symb), .m_symb_last(m0_symb_last),
        .seed_out(seed0), .seed_vld(seed0_vld), .err_align(err0));

    descrambler_par #(.DW(1), .N_SYMB_BITS(127), .START_SYMB(3), .SEED_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tready(s1_tready),
        .s_tlast(s1_tlast), .s_symb_cnt(s1_symb), .m_tdata(m1_tdata), .m_tvalid(m1_tvalid),
        .m_tready(m1_tready), .m_tlast(m1_tlast), .m_symb_cnt(m1_symb), .m_symb_last(m1_symb_last),
        .seed_out(seed1), .seed_vld(seed1_vld), .err_align(err1));

    descrambler_par #(.DW(8), .N_SYMB_BITS(96), .START_SYMB(3), .SEED_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .s_tdata(s2_tdata), .s_tvalid(s2_tvalid), .s_tready(s2_tready),
        .s_tlast(s2_tlast), .s_symb_cnt(s2_symb), .m_tdata(m2_tdata), .m_tvalid(m2_tvalid),
        .m_tready(m2_tready), .m_tlast(m2_tlast), .m_symb_cnt(m2_symb), .m_symb_last(m2_symb_last),
        .seed_out(seed2), .seed_vld(seed2_vld), .err_align(err2));

    // Keystream from seed 1011101 via k[n] = k[n-7] ^ k[n-4]; entry 7+n holds bit n.
    logic ksb [0:262];

    function automatic logic [7:0] ks_byte(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ksb[7 + 8*b + i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] symb;
        logic       last;
        logic [7:0] din;
        logic [7:0] dout;
        logic       slast;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [7:0] symb, input logic last, input logic [7:0] din,
                           input logic [7:0] dout, input logic slast, input logic err);
        vec_t v;
        v.symb = symb; v.last = last; v.din = din; v.dout = dout; v.slast = slast; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic beat0(input logic [7:0] symb, input logic last, input logic [7:0] din);
        s0_tvalid = 1'b1; s0_symb = symb; s0_tlast = last; s0_tdata = din; m0_tready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [7:0] bp_din [0:23];
    logic [7:0] bp_exp [0:23];
    logic [6:0] seed_c;

    initial begin
        int         tx, rx;
        logic       held, acc;
        logic [7:0] held_data, d;

        seed_c = 7'b1011101;
        for (int j = 0; j < 7; j++) ksb[6-j] = seed_c[j];
        for (int n = 0; n < 256; n++) ksb[7+n] = ksb[n] ^ ksb[n+3];

        rst = 1'b1;
        {s0_tdata, s0_tvalid, s0_tlast, s0_symb} = '0; m0_tready = 1'b1;
        {s1_tdata, s1_tvalid, s1_tlast, s1_symb} = '0; m1_tready = 1'b1;
        {s2_tdata, s2_tvalid, s2_tlast, s2_symb} = '0; m2_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready_low", s0_tready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_m_tvalid", m0_tvalid, 0);
        check("rst_m_tdata", m0_tdata, 0);
        check("rst_seed_vld", seed0_vld, 0);
        check("rst_seed_out", seed0, 0);
        check("rst_err", err0, 0);
        check("rst_symb_last", m0_symb_last, 0);
        check("rst_s_tready", s0_tready, 1);
        check("rst_m1_tvalid", m1_tvalid, 0);

        // Frame A: pass-through symbols, one full scrambled symbol, then a short symbol with tlast.
        add_vec(8'd0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        add_vec(8'd1, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0);
        add_vec(8'd2, 1'b0, 8'hF0, 8'hF0, 1'b0, 1'b0);
        add_vec(8'd3, 1'b0, 8'h00, 8'h36, 1'b0, 1'b0);
        for (int j = 1; j < 12; j++) begin
            d = 8'(j * 29);
            add_vec(8'd3, 1'b0, d, d ^ ks_byte(j), j == 11, 1'b0);
        end
        add_vec(8'd4, 1'b0, 8'h5A, 8'h5A ^ ks_byte(12), 1'b0, 1'b0);
        add_vec(8'd4, 1'b1, 8'hC3, 8'hC3 ^ ks_byte(13), 1'b0, 1'b0);
        // Frame B: symbol index changes after 40 bits; last beat ends both symbol and frame.
        for (int j = 0; j < 17; j++) begin
            d = 8'(j * 17 + 1);
            add_vec(j < 5 ? 8'd3 : 8'd4, j == 16, d, d ^ ks_byte(j), j == 16, j == 5);
        end

        foreach (tbl[i]) begin
            beat0(tbl[i].symb, tbl[i].last, tbl[i].din);
            check($sformatf("vec%0d_tvalid", i), m0_tvalid, 1);
            check($sformatf("vec%0d_tdata", i), m0_tdata, tbl[i].dout);
            check($sformatf("vec%0d_symb_last", i), m0_symb_last, tbl[i].slast);
            check($sformatf("vec%0d_tlast", i), m0_tlast, tbl[i].last);
            check($sformatf("vec%0d_symb_cnt", i), m0_symb, tbl[i].symb);
            check($sformatf("vec%0d_err", i), err0, tbl[i].err);
            if (i == 3) begin
                check("seed_loaded", seed0, 7'b1011101);
                check("seed_vld_set", seed0_vld, 1);
            end
            if (tbl[i].last) check($sformatf("vec%0d_seed_vld_clr", i), seed0_vld, 0);
        end
        s0_tvalid = 1'b0; s0_tlast = 1'b0;
        @(posedge clk); #1;
        check("idle_tvalid_clear", m0_tvalid, 0);
        check("idle_err_clear", err0, 0);

        // Backpressure: continuous s_tvalid, m_tready high about 30% of cycles.
        for (int j = 0; j < 24; j++) begin
            bp_din[j] = 8'($urandom);
            bp_exp[j] = bp_din[j] ^ ks_byte(j);
        end
        tx = 0; rx = 0; held = 1'b0; held_data = '0;
        for (int cyc = 0; cyc < 600 && rx < 24; cyc++) begin
            m0_tready = ($urandom_range(0, 9) < 3);
            s0_tvalid = (tx < 24);
            s0_tdata  = bp_din[tx < 24 ? tx : 0];
            s0_symb   = (tx < 12) ? 8'd3 : 8'd4;
            s0_tlast  = (tx == 23);
            #1;
            if (held) check("bp_stable", m0_tdata, held_data);
            if (m0_tvalid && m0_tready) begin
                check($sformatf("bp_data%0d", rx), m0_tdata, bp_exp[rx]);
                rx++;
            end
            held      = m0_tvalid && !m0_tready;
            held_data = m0_tdata;
            acc       = s0_tvalid && s0_tready;
            @(posedge clk); #1;
            if (acc) tx++;
        end
        check("bp_count", rx, 24);
        s0_tvalid = 1'b0; s0_tlast = 1'b0; m0_tready = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a frame, then a clean frame with a restart inside RUN.
        beat0(8'd3, 1'b0, 8'h00);
        check("pre_rst_data", m0_tdata, 8'h36);
        beat0(8'd3, 1'b0, 8'h00);
        s0_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_tvalid", m0_tvalid, 0);
        check("mid_rst_seed_vld", seed0_vld, 0);
        for (int j = 0; j < 24; j++) begin
            beat0(j < 12 ? 8'd3 : 8'd4, 1'b0, 8'h00);
            check($sformatf("post_rst%0d", j), m0_tdata, ks_byte(j));
            if (j == 11 || j == 23) check($sformatf("post_rst%0d_slast", j), m0_symb_last, 1);
        end
        beat0(8'd3, 1'b0, 8'h00);
        check("restart_data", m0_tdata, 8'h36);
        check("restart_err", err0, 1);
        check("restart_seed_vld", seed0_vld, 1);
        beat0(8'd3, 1'b1, 8'h00);
        check("restart_next", m0_tdata, ks_byte(1));
        check("restart_err_pulse", err0, 0);
        check("restart_end_vld", seed0_vld, 0);
        s0_tvalid = 1'b0; s0_tlast = 1'b0;

        // Seed recovery, one bit per beat over the whole 127-bit sequence.
        for (int j = 0; j < 127; j++) begin
            s1_tvalid = 1'b1; s1_symb = 8'd3; s1_tlast = (j == 126); s1_tdata = ksb[7+j];
            @(posedge clk); #1;
            check($sformatf("rec_bit%0d", j), m1_tdata, 0);
            if (j == 5) check("rec_vld_early", seed1_vld, 0);
            if (j == 6) begin
                check("rec_vld", seed1_vld, 1);
                check("rec_seed", seed1, 7'b0110110);
            end
        end
        check("rec_symb_last", m1_symb_last, 1);
        check("rec_tlast", m1_tlast, 1);
        check("rec_vld_end", seed1_vld, 0);
        s1_tvalid = 1'b0; s1_tlast = 1'b0;

        // Seed recovery finishing after 7 of 8 bits; bit 7 already descrambled.
        s2_tvalid = 1'b1; s2_symb = 8'd3; s2_tlast = 1'b0; s2_tdata = ks_byte(0) ^ 8'h80;
        @(posedge clk); #1;
        check("rec8_b0", m2_tdata, 8'h80);
        check("rec8_vld", seed2_vld, 1);
        check("rec8_seed", seed2, 7'b0110110);
        s2_tdata = ks_byte(1) ^ 8'hA5;
        @(posedge clk); #1;
        check("rec8_b1", m2_tdata, 8'hA5);
        s2_tlast = 1'b1; s2_tdata = ks_byte(2) ^ 8'h5A;
        @(posedge clk); #1;
        check("rec8_b2", m2_tdata, 8'h5A);
        check("rec8_vld_end", seed2_vld, 0);
        s2_tvalid = 1'b0; s2_tlast = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
